// File: rtl/core_pkg.sv
// core_pkg: shared register-file constants and the address legality check.
// Holds the ISA register counts (RV32I / RV32E), the register address width and
// reg_valid(), which accepts only non-zero addresses below the register count.
package core_pkg;
  localparam int REG_ADDR_W     = 5;
  localparam int NUM_REGS_RV32I = 32;
  localparam int NUM_REGS_RV32E = 16;

  function automatic logic reg_valid(input logic [REG_ADDR_W-1:0] addr, input int num_regs);
    return (addr != '0) && (int'(addr) < num_regs);
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
// Ports:
//   i_rst      - reset level, forces the port to read 0 / not busy
//   i_addr     - read address
//   i_regs     - register array contents
//   i_busy     - pending-write bits
//   i_wb_*     - current write-back, forwarded when BYPASS is set
//   o_rd_data  - read data
//   o_rd_busy  - addressed register has an outstanding write
module regfile_read_port
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic                           i_rst,
  input  logic [REG_ADDR_W-1:0]          i_addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  i_regs,
  input  logic [NUM_REGS-1:0]            i_busy,
  input  logic                           i_wb_en,
  input  logic [REG_ADDR_W-1:0]          i_wb_addr,
  input  logic [XLEN-1:0]                i_wb_data,
  output logic [XLEN-1:0]                o_rd_data,
  output logic                           o_rd_busy
);
  localparam int IW = $clog2(NUM_REGS);

  logic          w_valid;
  logic          w_hit;
  logic [IW-1:0] w_idx;

  // x0 and out-of-range addresses read as 0 / not busy; the index is only
  // used once the address is known to be in range, so no aliasing occurs.
  always_comb begin
    w_valid   = reg_valid(i_addr, NUM_REGS);
    w_hit     = (BYPASS != 0) && i_wb_en && (i_wb_addr == i_addr);
    w_idx     = i_addr[IW-1:0];
    o_rd_data = (i_rst || !w_valid) ? '0 : w_hit ? i_wb_data : i_regs[w_idx];
    o_rd_busy = !i_rst && w_valid && !w_hit && i_busy[w_idx];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending-write scoreboard.
// Ports:
//   clk_i, reset_i         - clock, asynchronous active-high reset
//   rd_addr_i / rd_data_o  - NUM_READ_PORTS combinational read ports, packed per port
//   rd_busy_o              - per-port busy flag of the addressed register
//   wb_en_i/addr/data      - write-back, clears the destination busy bit
//   issue_en_i/addr        - issue of a producer, sets the destination busy bit
//   flush_i                - clears every busy bit, overrides issue
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = NUM_REGS_RV32I,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr_i,
  output logic [NUM_READ_PORTS*XLEN-1:0]       rd_data_o,
  output logic [NUM_READ_PORTS-1:0]            rd_busy_o,
  input  logic                                 wb_en_i,
  input  logic [REG_ADDR_W-1:0]                wb_addr_i,
  input  logic [XLEN-1:0]                      wb_data_i,
  input  logic                                 issue_en_i,
  input  logic [REG_ADDR_W-1:0]                issue_addr_i,
  input  logic                                 flush_i
);
  logic [NUM_REGS-1:0][XLEN-1:0] r_regs;
  logic [NUM_REGS-1:0]           r_busy;
  logic                          w_wb_ok;
  logic                          w_iss_ok;

  // Flush suppresses the issue so a flushed producer never leaves a mark.
  always_comb begin
    w_wb_ok  = wb_en_i && reg_valid(wb_addr_i, NUM_REGS);
    w_iss_ok = issue_en_i && !flush_i && reg_valid(issue_addr_i, NUM_REGS);
  end

  // Entry 0 is never addressed by a valid write or issue, so it stays 0.
  // Issue is checked before the write-back clear: a new producer wins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wb_ok && wb_addr_i == REG_ADDR_W'(r)) r_regs[r] <= wb_data_i;
        r_busy[r] <= (w_iss_ok && issue_addr_i == REG_ADDR_W'(r)) ? 1'b1 :
                     (flush_i || (w_wb_ok && wb_addr_i == REG_ADDR_W'(r))) ? 1'b0 : r_busy[r];
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
    ) u_port (
      .i_rst     (reset_i),
      .i_addr    (rd_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_wb_en   (wb_en_i),
      .i_wb_addr (wb_addr_i),
      .i_wb_data (wb_data_i),
      .o_rd_data (rd_data_o[p*XLEN +: XLEN]),
      .o_rd_busy (rd_busy_o[p])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench for three configurations of regfile_scoreboard.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wb_en = 1'b0, ien = 1'b0, flush = 1'b0;
  logic [4:0]  wb_addr = '0, iaddr = '0;
  logic [31:0] wb_data = '0;
  logic [63:0] d0, d1, d2;
  logic [1:0]  b0, b1, b2;

  typedef struct packed {
    logic [191:0] d;
    logic [5:0]   b;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_reg [3][32];
  bit          m_busy[3][32];
  int          nregs [3] = '{32, 32, 16};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .BYPASS(1)) u_byp (
    .clk_i(clk), .reset_i(rst), .rd_addr_i(rd_addr), .rd_data_o(d0), .rd_busy_o(b0),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .issue_en_i(ien), .issue_addr_i(iaddr), .flush_i(flush));

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .BYPASS(0)) u_nobyp (
    .clk_i(clk), .reset_i(rst), .rd_addr_i(rd_addr), .rd_data_o(d1), .rd_busy_o(b1),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .issue_en_i(ien), .issue_addr_i(iaddr), .flush_i(flush));

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(16), .NUM_READ_PORTS(2), .BYPASS(1)) u_rv32e (
    .clk_i(clk), .reset_i(rst), .rd_addr_i(rd_addr), .rd_data_o(d2), .rd_busy_o(b2),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .issue_en_i(ien), .issue_addr_i(iaddr), .flush_i(flush));

  function automatic bit valid(int k, logic [4:0] a);
    return a != 0 && int'(a) < nregs[k];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit ie, input logic [4:0] ia, input bit fl,
                      input logic [4:0] a0, input logic [4:0] a1);
    exp_t        e;
    logic [4:0]  ra;
    logic [31:0] dat;
    bit          bz;
    rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
    ien = ie; iaddr = ia; flush = fl; rd_addr = {a1, a0};
    e = '0;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        ra  = (p == 1) ? a1 : a0;
        dat = '0;
        bz  = 1'b0;
        if (!r && valid(k, ra)) begin
          if (byp[k] && we && wa == ra) dat = wd;
          else begin
            dat = m_reg[k][ra];
            bz  = m_busy[k][ra];
          end
        end
        e.d[(2*k+p)*32 +: 32] = dat;
        e.b[2*k+p]            = bz;
      end
    q.push_back(e);
    if (r) clear_model();
    else
      for (int k = 0; k < 3; k++) begin
        if (we && valid(k, wa)) m_reg[k][wa] = wd;
        if (fl) for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
        else begin
          if (we && valid(k, wa)) m_busy[k][wa] = 1'b0;
          if (ie && valid(k, ia)) m_busy[k][ia] = 1'b1;
        end
      end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t         e;
    logic [191:0] gd;
    logic [5:0]   gb;
    if (q.size() > 0) begin
      e  = q.pop_front();
      gd = {d2, d1, d0};
      gb = {b2, b1, b0};
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gd[k*64 +: 64] !== e.d[k*64 +: 64]) begin
          errors++;
          $display("FAIL dut%0d rd_data @%0t got %h exp %h", k, $time, gd[k*64 +: 64], e.d[k*64 +: 64]);
        end
        checks++;
        if (gb[k*2 +: 2] !== e.b[k*2 +: 2]) begin
          errors++;
          $display("FAIL dut%0d rd_busy @%0t got %b exp %b", k, $time, gb[k*2 +: 2], e.b[k*2 +: 2]);
        end
      end
    end
  end

  initial begin
    bit          r, we, ie, fl;
    logic [4:0]  wa, ia, a0, a1;
    clear_model();
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5);
    step(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7, 7);
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 32'hCAFEF00D, 0, 0, 0, 7, 3);
    step(0, 0, 0, 0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 1, 9, 0, 9, 3);
    step(0, 0, 0, 0, 0, 0, 0, 9, 9);
    step(0, 1, 9, 32'h99, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 1, 9, 0, 9, 9);
    step(0, 1, 9, 32'h77, 1, 9, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 1, 4, 0, 4, 5);
    step(0, 0, 0, 0, 1, 5, 0, 4, 5);
    step(0, 0, 0, 0, 1, 6, 0, 5, 6);
    step(0, 0, 0, 0, 1, 8, 1, 4, 8);
    step(0, 0, 0, 0, 0, 0, 0, 4, 8);
    step(0, 0, 0, 0, 0, 0, 0, 5, 6);
    step(0, 1, 4, 32'h44, 0, 0, 0, 4, 4);
    step(0, 1, 20, 32'h55, 0, 0, 0, 20, 4);
    step(0, 0, 0, 0, 1, 20, 0, 20, 4);
    step(0, 0, 0, 0, 0, 0, 0, 20, 4);
    step(0, 0, 0, 0, 1, 4, 0, 4, 5);
    step(1, 1, 4, 32'hBAD, 1, 5, 0, 4, 5);
    step(0, 0, 0, 0, 0, 0, 0, 4, 5);
    repeat (600) begin
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(0, 31));
      ie = ($urandom_range(0, 2) == 0);
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      fl = ($urandom_range(0, 19) == 0);
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom_range(0, 31));
      step(r, we, wa, $urandom, ie, ia, fl, a0, a1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
